// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues icache reads and buffers words in a prefetch FIFO.
// Optional build macro IFETCH_STATS_EN adds fetch/stall statistics counters.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic [31:0] address,
  output logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        ihit,
  input  logic [31:0] memout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        halted
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic {S_FETCH, S_HALT} state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_pc, w_pc_next, r_addr;
  logic [31:0]   r_mem_pc  [BUF_DEPTH];
  logic [31:0]   r_mem_ins [BUF_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_iren, w_hit, w_flush, w_push, w_pop;
  logic          w_unused_rpc;

  assign w_unused_rpc = |redirect_pc[1:0];

  // nRST gates the request so iREN drops immediately on an asynchronous reset.
  assign w_full  = (r_count == CW'(BUF_DEPTH));
  assign w_iren  = nRST & (r_state == S_FETCH) & ~dREN & ~dWEN & ~w_full;
  assign w_hit   = w_iren & ihit;
  assign w_flush = (r_state == S_FETCH) & redirect;
  assign w_push  = w_hit & ~w_flush;
  assign w_pop   = instr_valid & instr_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (r_state == S_FETCH && halt) w_state_next = S_HALT;
    if (w_flush)     w_pc_next = {redirect_pc[31:2], 2'b00};
    else if (w_push) w_pc_next = r_pc + 32'd4;
  end

  // r_addr remembers where the last request left the PC, so a stalled port shows the next fetch address.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc   <= RESET_PC;
      r_addr <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
      if (w_iren) r_addr <= w_pc_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem_pc[i]  <= '0;
        r_mem_ins[i] <= '0;
      end
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]  <= r_pc;
        r_mem_ins[r_wr_ptr] <= memout;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign iREN        = w_iren;
  assign address     = w_iren ? r_pc : r_addr;
  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_mem_ins[r_rd_ptr] : '0;
  assign instr_pc    = instr_valid ? r_mem_pc[r_rd_ptr]  : '0;
  assign halted      = (r_state == S_HALT);

`ifdef IFETCH_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_push) fetch_cnt <= fetch_cnt + 32'd1;
      if (r_state == S_FETCH && !w_iren) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: table-driven cycle vectors plus hand sequences for reset and PC wrap.
module tb_ifetch_unit;

  logic        CLK = 0;
  logic        nRST = 0;
  logic        dREN = 0, dWEN = 0, ihit = 0, redirect = 0, halt = 0, instr_ready = 0;
  logic [31:0] memout = 0, redirect_pc = 0;

  logic [31:0] address, instr, instr_pc;
  logic        iREN, instr_valid, halted;
  logic [31:0] w_address, w_instr, w_instr_pc;
  logic        w_iREN, w_instr_valid, w_halted;
`ifdef IFETCH_STATS_EN
  logic [31:0] fc0, sc0, fc1, sc1;
`endif

  ifetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .CLK(CLK), .nRST(nRST), .address(address), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .ihit(ihit), .memout(memout), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .halted(halted)
`ifdef IFETCH_STATS_EN
    , .fetch_cnt(fc0), .stall_cnt(sc0)
`endif
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_w (
    .CLK(CLK), .nRST(nRST), .address(w_address), .iREN(w_iREN), .dREN(dREN), .dWEN(dWEN),
    .ihit(ihit), .memout(memout), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(instr_ready),
    .halted(w_halted)
`ifdef IFETCH_STATS_EN
    , .fetch_cnt(fc1), .stall_cnt(sc1)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          rst;
    bit          dren, dwen, ihit;
    logic [31:0] mem;
    bit          redir;
    logic [31:0] rpc;
    bit          halt, rdy;
    bit          e_iren;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_ipc, e_ins;
    bit          e_halted;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] M(input logic [31:0] p);
    return p ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t v(input bit rst, dren, dwen, hit, input logic [31:0] mem,
                             input bit redir, input logic [31:0] rpc, input bit hlt, rdy,
                             input bit e_iren, input logic [31:0] e_addr, input bit e_valid,
                             input logic [31:0] e_ipc, e_ins, input bit e_halted);
    vec_t t;
    t.rst = rst; t.dren = dren; t.dwen = dwen; t.ihit = hit; t.mem = mem;
    t.redir = redir; t.rpc = rpc; t.halt = hlt; t.rdy = rdy;
    t.e_iren = e_iren; t.e_addr = e_addr; t.e_valid = e_valid;
    t.e_ipc = e_ipc; t.e_ins = e_ins; t.e_halted = e_halted;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dREN = 0; dWEN = 0; ihit = 0; memout = 0; redirect = 0; redirect_pc = 0;
    halt = 0; instr_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;
  endtask

  initial begin
    // T2 streaming
    vecs.push_back(v(1,0,0,1,M(0),0,0,0,1, 1,32'h0,0,32'h0,32'h0,0));
    vecs.push_back(v(0,0,0,1,M(4),0,0,0,1, 1,32'h4,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,1,M(8),0,0,0,1, 1,32'h8,1,32'h4,M(4),0));
    vecs.push_back(v(0,0,0,1,M(12),0,0,0,1, 1,32'hC,1,32'h8,M(8),0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 1,32'h10,1,32'hC,M(12),0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 1,32'h10,0,32'h0,32'h0,0));
    // T3 backpressure
    vecs.push_back(v(1,0,0,1,M(0),0,0,0,0, 1,32'h0,0,32'h0,32'h0,0));
    vecs.push_back(v(0,0,0,1,M(4),0,0,0,0, 1,32'h4,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,1,M(8),0,0,0,0, 0,32'h8,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0, 0,32'h8,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,32'h8,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 1,32'h8,1,32'h4,M(4),0));
    vecs.push_back(v(0,0,0,1,M(8),0,0,0,1, 1,32'h8,0,32'h0,32'h0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 1,32'hC,1,32'h8,M(8),0));
    // T4 redirect
    vecs.push_back(v(1,0,0,1,M(0),0,0,0,1, 1,32'h0,0,32'h0,32'h0,0));
    vecs.push_back(v(0,0,0,1,M(4),0,0,0,1, 1,32'h4,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,1,M(8),0,0,0,1, 1,32'h8,1,32'h4,M(4),0));
    vecs.push_back(v(0,0,0,1,M(12),0,0,0,1, 1,32'hC,1,32'h8,M(8),0));
    vecs.push_back(v(0,0,0,1,M(16),1,32'h103,0,1, 1,32'h10,1,32'hC,M(12),0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 1,32'h100,0,32'h0,32'h0,0));
    vecs.push_back(v(0,0,0,1,M(32'h100),0,0,0,1, 1,32'h100,0,32'h0,32'h0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0, 1,32'h104,1,32'h100,M(32'h100),0));
    // T5 data yield
    vecs.push_back(v(1,0,0,1,M(0),0,0,0,0, 1,32'h0,0,32'h0,32'h0,0));
    vecs.push_back(v(0,1,0,1,32'hDEAD_BEEF,0,0,0,0, 0,32'h4,1,32'h0,M(0),0));
    vecs.push_back(v(0,1,0,1,32'hDEAD_BEEF,0,0,0,0, 0,32'h4,1,32'h0,M(0),0));
    vecs.push_back(v(0,1,0,0,0,0,0,0,0, 0,32'h4,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,1,1,32'hDEAD_BEEF,0,0,0,0, 0,32'h4,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,1,M(4),0,0,0,0, 1,32'h4,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,32'h8,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 1,32'h8,1,32'h4,M(4),0));
    // halt: same-cycle hit accepted, redirect ignored afterwards, FIFO drains
    vecs.push_back(v(1,0,0,1,M(0),0,0,0,0, 1,32'h0,0,32'h0,32'h0,0));
    vecs.push_back(v(0,0,0,1,M(4),0,0,1,0, 1,32'h4,1,32'h0,M(0),0));
    vecs.push_back(v(0,0,0,1,M(8),1,32'h200,0,1, 0,32'h8,1,32'h0,M(0),1));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,32'h8,1,32'h4,M(4),1));
    vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,32'h8,0,32'h0,32'h0,1));

    // T1 reset values
    do_reset();
    nRST = 0;
    #1;
    chk("rst_iren", {31'b0, iREN}, 32'h0);
    chk("rst_addr", address, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    nRST = 1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge CLK);
      dREN = vecs[i].dren; dWEN = vecs[i].dwen; ihit = vecs[i].ihit; memout = vecs[i].mem;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc; halt = vecs[i].halt;
      instr_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_iren", i), {31'b0, iREN}, {31'b0, vecs[i].e_iren});
      chk($sformatf("v%0d_addr", i), address, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_ipc", i), instr_pc, vecs[i].e_ipc);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].e_ins);
      chk($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halted});
    end

    // T1 mid-run async reset with FIFO full
    do_reset();
    @(negedge CLK); ihit = 1; memout = M(0);
    @(negedge CLK); memout = M(4);
    @(negedge CLK); ihit = 0;
    #1;
    chk("t1_full_iren", {31'b0, iREN}, 32'h0);
    chk("t1_full_valid", {31'b0, instr_valid}, 32'h1);
    #2 nRST = 0;
    #1;
    chk("t1_async_iren", {31'b0, iREN}, 32'h0);
    chk("t1_async_valid", {31'b0, instr_valid}, 32'h0);
    chk("t1_async_addr", address, 32'h0);
    chk("t1_async_ipc", instr_pc, 32'h0);
    @(negedge CLK);
    nRST = 1;
    #1;
    chk("t1_release_iren", {31'b0, iREN}, 32'h1);
    chk("t1_release_addr", address, 32'h0);

    // T6 PC wrap then halt, on the instance reset to 0xFFFF_FFFC
    do_reset();
    @(negedge CLK); ihit = 1; memout = 32'h1234_5678;
    #1;
    chk("t6_iren", {31'b0, w_iREN}, 32'h1);
    chk("t6_addr0", w_address, 32'hFFFF_FFFC);
    @(negedge CLK); ihit = 0; halt = 1;
    #1;
    chk("t6_wrap_addr", w_address, 32'h0);
    chk("t6_ipc", w_instr_pc, 32'hFFFF_FFFC);
    chk("t6_instr", w_instr, 32'h1234_5678);
    @(negedge CLK); halt = 0;
    #1;
    chk("t6_halted", {31'b0, w_halted}, 32'h1);
    chk("t6_halt_iren", {31'b0, w_iREN}, 32'h0);
    chk("t6_halt_valid", {31'b0, w_instr_valid}, 32'h1);
    instr_ready = 1;
    @(negedge CLK); instr_ready = 0;
    #1;
    chk("t6_drained", {31'b0, w_instr_valid}, 32'h0);
    chk("t6_still_halted", {31'b0, w_halted}, 32'h1);
    chk("t6_still_iren", {31'b0, w_iREN}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
